// File: rtl/core_decode_pkg.sv
// core_decode_pkg: opcodes, immediate types and the buffered decode entry shared by the decode stage.
package core_decode_pkg;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR} imm_type_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      opcode;
    logic            illegal;
  } decode_entry_t;
endpackage

// File: rtl/decode_imm_stage_if.sv
// decode_imm_stage_if: fetch-side and execute-side handshake plus decoded fields of the decode stage.
interface decode_imm_stage_if;
  import core_decode_pkg::*;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  imm_type_e   out_imm_type;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [6:0]  out_opcode;
  logic        out_illegal;
  modport master (output flush, in_valid, in_instr, in_pc, out_ready,
                  input in_ready, out_valid, out_pc, out_imm, out_imm_type, out_rd, out_rs1, out_rs2,
                        out_funct3, out_funct7, out_opcode, out_illegal);
  modport slave (input flush, in_valid, in_instr, in_pc, out_ready,
                 output in_ready, out_valid, out_pc, out_imm, out_imm_type, out_rd, out_rs1, out_rs2,
                        out_funct3, out_funct7, out_opcode, out_illegal);
endinterface

// File: rtl/decode_skid_fifo.sv
// decode_skid_fifo: 2-entry decode buffer with flush; presents the last popped entry while empty.
module decode_skid_fifo
  import core_decode_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  decode_entry_t din,
  output logic          out_valid,
  input  logic          out_ready,
  output decode_entry_t dout
);
  decode_entry_t mem [DEPTH];
  decode_entry_t last_q;
  logic [1:0]    count;
  logic          wr_ptr, rd_ptr, push, pop;
  assign in_ready  = count != 2'(DEPTH);
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign dout      = out_valid ? mem[rd_ptr] : last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      last_q <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      if (pop) last_q <= mem[rd_ptr];
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/sign_extend_B.sv
// sign_extend_B: B-type immediate, 13-bit branch offset with implicit zero LSB.
module sign_extend_B (
  input  logic [6:0]  in1,
  input  logic [4:0]  in2,
  output logic [31:0] out
);
  assign out = {19'b0, in1[6], in2[0], in1[5:0], in2[4:1], 1'b0};
endmodule

// File: rtl/sign_extend_I.sv
// sign_extend_I: I-type immediate; shift-immediate funct3 values keep only shamt.
module sign_extend_I (
  input  logic [11:0] in,
  input  logic [2:0]  funct,
  output logic [31:0] out
);
  assign out = (funct == 3'b001 || funct == 3'b101) ? {27'b0, in[4:0]} : {20'b0, in};
endmodule

// File: rtl/sign_extend_J.sv
// sign_extend_J: J-type immediate, 21-bit jump offset with implicit zero LSB.
module sign_extend_J (
  input  logic [19:0] in,
  output logic [31:0] out
);
  assign out = {11'b0, in[19], in[7:0], in[8], in[18:9], 1'b0};
endmodule

// File: rtl/sign_extend_S.sv
// sign_extend_S: S-type immediate assembled from the split store offset.
module sign_extend_S (
  input  logic [6:0]  in1,
  input  logic [4:0]  in2,
  output logic [31:0] out
);
  assign out = {20'b0, in1, in2};
endmodule

// File: rtl/sign_extend_U.sv
// sign_extend_U: U-type immediate placed in the upper 20 bits.
module sign_extend_U (
  input  logic [19:0] in,
  output logic [31:0] out
);
  assign out = {in, 12'b0};
endmodule

// File: rtl/sign_extend_csr.sv
// sign_extend_csr: 5-bit CSR zimm operand.
module sign_extend_csr (
  input  logic [4:0]  in,
  output logic [31:0] out
);
  assign out = {27'b0, in};
endmodule

// File: rtl/decode_imm_stage.sv
// decode_imm_stage: classifies fetched instructions, builds the immediate and buffers the result for execute.
module decode_imm_stage
  import core_decode_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  decode_imm_stage_if.slave bus
);
  logic [31:0]   instr, imm_i, imm_s, imm_b, imm_u, imm_j, imm_c;
  logic [6:0]    opc;
  imm_type_e     typ;
  decode_entry_t din, head;
  assign instr = bus.in_instr;
  assign opc   = instr[6:0];
  // only OP-IMM shifts may truncate to shamt; loads, jalr and csr addresses keep all 12 bits
  sign_extend_I   u_imm_i (.in(instr[31:20]), .funct(opc == OP_IMM ? instr[14:12] : 3'b000), .out(imm_i));
  sign_extend_S   u_imm_s (.in1(instr[31:25]), .in2(instr[11:7]), .out(imm_s));
  sign_extend_B   u_imm_b (.in1(instr[31:25]), .in2(instr[11:7]), .out(imm_b));
  sign_extend_U   u_imm_u (.in(instr[31:12]), .out(imm_u));
  sign_extend_J   u_imm_j (.in(instr[31:12]), .out(imm_j));
  sign_extend_csr u_imm_c (.in(instr[19:15]), .out(imm_c));
  always_comb begin
    typ = (opc == OP_LUI || opc == OP_AUIPC) ? IMM_U :
          (opc == OP_JAL) ? IMM_J :
          (opc == OP_JALR || opc == OP_LOAD || opc == OP_IMM) ? IMM_I :
          (opc == OP_STORE) ? IMM_S :
          (opc == OP_BRANCH) ? IMM_B :
          (opc == OP_SYSTEM) ? (instr[14] ? IMM_CSR : IMM_I) : IMM_NONE;
    din          = '0;
    din.pc       = bus.in_pc;
    din.imm      = typ == IMM_I ? imm_i : typ == IMM_S ? imm_s : typ == IMM_B ? imm_b :
                   typ == IMM_U ? imm_u : typ == IMM_J ? imm_j : typ == IMM_CSR ? imm_c : 32'b0;
    din.imm_type = typ;
    din.rd       = instr[11:7];
    din.rs1      = instr[19:15];
    din.rs2      = instr[24:20];
    din.funct3   = instr[14:12];
    din.funct7   = instr[31:25];
    din.opcode   = opc;
    din.illegal  = typ == IMM_NONE && opc != OP_REG;
  end
  decode_skid_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .din      (din),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .dout     (head)
  );
  assign bus.out_pc       = head.pc;
  assign bus.out_imm      = head.imm;
  assign bus.out_imm_type = head.imm_type;
  assign bus.out_rd       = head.rd;
  assign bus.out_rs1      = head.rs1;
  assign bus.out_rs2      = head.rs2;
  assign bus.out_funct3   = head.funct3;
  assign bus.out_funct7   = head.funct7;
  assign bus.out_opcode   = head.opcode;
  assign bus.out_illegal  = head.illegal;
endmodule

// File: tb/tb_decode_imm_stage.sv
// tb_decode_imm_stage: directed and random stimulus against a queue-based reference of the decode stage.
module tb_decode_imm_stage;
  import core_decode_pkg::*;
  logic clk, rst_n;
  int checks, errors;
  decode_entry_t q[$];
  decode_entry_t last;
  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h73, 7'h7F};
  decode_imm_stage_if bus();
  decode_imm_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic decode_entry_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    decode_entry_t d;
    int f3;
    d = '0;
    f3 = int'((i >> 12) & 7);
    d.pc = pc; d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20];
    d.funct3 = i[14:12]; d.funct7 = i[31:25]; d.opcode = i[6:0];
    case (i[6:0])
      7'h37, 7'h17: begin d.imm_type = IMM_U; d.imm = i & 32'hFFFFF000; end
      7'h6F: begin
        d.imm_type = IMM_J;
        d.imm = (((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12) | (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1);
      end
      7'h67, 7'h03: begin d.imm_type = IMM_I; d.imm = i >> 20; end
      7'h13: begin d.imm_type = IMM_I; d.imm = (f3 == 1 || f3 == 5) ? ((i >> 20) & 31) : (i >> 20); end
      7'h23: begin d.imm_type = IMM_S; d.imm = ((i >> 25) << 5) | ((i >> 7) & 31); end
      7'h63: begin
        d.imm_type = IMM_B;
        d.imm = (((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1);
      end
      7'h33: d.imm_type = IMM_NONE;
      7'h73: if (f3 >= 4) begin d.imm_type = IMM_CSR; d.imm = (i >> 15) & 31; end
             else begin d.imm_type = IMM_I; d.imm = i >> 20; end
      default: begin d.imm_type = IMM_NONE; d.illegal = 1'b1; end
    endcase
    return d;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_state();
    decode_entry_t h;
    h = (q.size() != 0) ? q[0] : last;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() != 2));
    chk("out_pc", bus.out_pc, h.pc);
    chk("out_imm", bus.out_imm, h.imm);
    chk("out_imm_type", 32'(bus.out_imm_type), 32'(h.imm_type));
    chk("out_rd", 32'(bus.out_rd), 32'(h.rd));
    chk("out_rs1", 32'(bus.out_rs1), 32'(h.rs1));
    chk("out_rs2", 32'(bus.out_rs2), 32'(h.rs2));
    chk("out_funct3", 32'(bus.out_funct3), 32'(h.funct3));
    chk("out_funct7", 32'(bus.out_funct7), 32'(h.funct7));
    chk("out_opcode", 32'(bus.out_opcode), 32'(h.opcode));
    chk("out_illegal", 32'(bus.out_illegal), 32'(h.illegal));
  endtask
  task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc, input bit rdy, input bit fl);
    bit push, pop;
    bus.in_valid = v; bus.in_instr = instr; bus.in_pc = pc; bus.out_ready = rdy; bus.flush = fl;
    if (fl) q.delete();
    else begin
      push = v && q.size() < 2;
      pop = q.size() > 0 && rdy;
      if (pop) last = q.pop_front();
      if (push) q.push_back(ref_decode(instr, pc));
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask
  task automatic rand_steps(input int n);
    logic [31:0] r;
    for (int k = 0; k < n; k++) begin
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 10) == 10) r[6:0] = 7'($urandom());
      step($urandom_range(0, 9) < 7, r, $urandom(), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
  endtask
  initial begin
    checks = 0; errors = 0; last = '0;
    rst_n = 0; bus.flush = 0; bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 0;
    #2;
    check_state();
    @(negedge clk);
    rst_n = 1;
    step(1, 32'h00500093, 32'h100, 1, 0);
    chk("addi_imm", bus.out_imm, 32'h5);
    chk("addi_type", 32'(bus.out_imm_type), 32'(IMM_I));
    chk("addi_rd", 32'(bus.out_rd), 32'd1);
    step(1, 32'h00309113, 32'h104, 1, 0);
    chk("slli_imm", bus.out_imm, 32'h3);
    step(1, 32'h04001083, 32'h108, 1, 0);
    chk("lh_imm", bus.out_imm, 32'h40);
    step(1, 32'hFE000EE3, 32'h10C, 1, 0);
    chk("beq_imm", bus.out_imm, 32'h1FFC);
    chk("beq_type", 32'(bus.out_imm_type), 32'(IMM_B));
    step(1, 32'h008000EF, 32'h110, 1, 0);
    chk("jal_imm", bus.out_imm, 32'h8);
    chk("jal_type", 32'(bus.out_imm_type), 32'(IMM_J));
    step(1, 32'h123452B7, 32'h114, 1, 0);
    chk("lui_imm", bus.out_imm, 32'h12345000);
    step(0, 32'h0, 32'h0, 1, 0);
    step(1, 32'h00A00113, 32'h200, 0, 0);
    step(1, 32'h00B00193, 32'h204, 0, 0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1, 32'h00C00213, 32'h208, 0, 0);
    chk("stall_head_pc", bus.out_pc, 32'h200);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("drain_first", bus.out_pc, 32'h204);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    step(1, 32'h00D00293, 32'h300, 0, 0);
    step(1, 32'h00E00313, 32'h304, 0, 0);
    step(1, 32'h00F00393, 32'h308, 0, 1);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("flush_drop", 32'(bus.out_valid), 32'd0);
    step(1, 32'h0000007F, 32'h400, 1, 0);
    chk("illegal_flag", 32'(bus.out_illegal), 32'd1);
    chk("illegal_type", 32'(bus.out_imm_type), 32'(IMM_NONE));
    chk("illegal_imm", bus.out_imm, 32'h0);
    rand_steps(400);
    step(1, 32'h00100093, 32'h500, 0, 0);
    step(1, 32'h00200093, 32'h504, 0, 0);
    #2;
    rst_n = 0;
    #1;
    q.delete();
    last = '0;
    check_state();
    @(negedge clk);
    rst_n = 1;
    rand_steps(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
